pci_rr_arbiter: RTL and testbench

PCI_RR_ARBITER -- requirements
Module: pci_rr_arbiter

---
 rtl/pci_rr_arbiter_pkg.sv | 22 ++
 rtl/pci_rr_pick.sv | 32 +++
 rtl/pci_rr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_pci_rr_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_rr_arbiter_pkg.sv
// Shared types and default constants for the PCI round-robin arbiter.
package pci_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_PARK  = 2'd3
  } arb_state_e;

  localparam int unsigned DEF_NUM_MASTERS = 5;
  localparam int unsigned DEF_GNT_TIMEOUT = 16;
  localparam int unsigned DEF_PARK_MASTER = 0;
  localparam int unsigned MAX_MASTERS     = 8;
  localparam int unsigned IDX_W           = 3;

  // One-hot vector for a master index, sized for the largest legal bus.
  function automatic logic [MAX_MASTERS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    idx_onehot = MAX_MASTERS'(1) << idx;
  endfunction

endpackage

// File: rtl/pci_rr_pick.sv
// Combinational round-robin selector: first requester after last_owner, wrapping.
module pci_rr_pick
  import pci_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_owner,
  output logic [IDX_W-1:0]       winner,
  output logic                   valid
);

  logic [MAX_MASTERS-1:0] req_pad;
  logic [IDX_W-1:0]       idx;

  // Scan from last_owner+1 around the ring; the first active request wins.
  always_comb begin
    req_pad                  = '0;
    req_pad[NUM_MASTERS-1:0] = req;
    idx                      = '0;
    winner                   = '0;
    valid                    = 1'b0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      idx = IDX_W'((32'(last_owner) + i) % NUM_MASTERS);
      if (!valid && req_pad[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pci_rr_arbiter.sv
// PCI bus arbiter: round-robin grants, bus parking and grant timeout.
module pci_rr_arbiter
  import pci_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int unsigned GNT_TIMEOUT = DEF_GNT_TIMEOUT,
  parameter int unsigned PARK_MASTER = DEF_PARK_MASTER
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req_n,
  input  logic                   frame_n,
  input  logic                   irdy_n,
  output logic [NUM_MASTERS-1:0] gnt_n,
  output logic [2:0]             owner,
  output logic                   bus_busy,
  output logic                   timeout_pulse
);

  localparam int unsigned      CNT_W    = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'((GNT_TIMEOUT > 0) ? GNT_TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] PARK_IDX = IDX_W'(PARK_MASTER);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_d;
  logic [IDX_W-1:0]       owner_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [IDX_W-1:0]       win_q, win_d;
  logic [IDX_W-1:0]       pick_win;
  logic                   pick_valid;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   tp_d;
  logic                   bus_idle;
  logic                   other_req;
  logic [MAX_MASTERS-1:0] req_pad;
  logic [MAX_MASTERS-1:0] own_mask;

  // Active-low grant vector selecting a single master.
  function automatic logic [NUM_MASTERS-1:0] grant_vec(input logic [IDX_W-1:0] idx);
    logic [MAX_MASTERS-1:0] oh;
    oh = idx_onehot(idx);
    return ~oh[NUM_MASTERS-1:0];
  endfunction

  assign bus_idle = frame_n & irdy_n;

  // Requests padded to the full index range (absent masters read as not requesting).
  always_comb begin
    req_pad                  = '1;
    req_pad[NUM_MASTERS-1:0] = req_n;
    own_mask                 = idx_onehot(owner);
    other_req                = |(~req_pad & ~own_mask);
  end

  // Round-robin pointer is kept apart from owner so a timed-out master can be skipped.
  pci_rr_pick #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_pick (
    .req        (~req_n),
    .last_owner (last_q),
    .winner     (pick_win),
    .valid      (pick_valid)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_n;
    owner_d = owner;
    last_d  = last_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    tp_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gnt_d = '1;
        if (bus_idle) begin
          if (pick_valid) begin
            state_d = ST_GRANT;
            win_d   = pick_win;
            gnt_d   = grant_vec(pick_win);
            cnt_d   = '0;
          end else begin
            state_d = ST_PARK;
            gnt_d   = grant_vec(PARK_IDX);
          end
        end
      end
      ST_PARK: begin
        if (!frame_n) begin
          state_d = ST_BUSY;
          owner_d = PARK_IDX;
          last_d  = PARK_IDX;
        end else if (!req_pad[PARK_IDX]) begin
          // Parked master already holds the grant, so no dead cycle is needed.
          state_d = ST_GRANT;
          win_d   = PARK_IDX;
          cnt_d   = '0;
        end else if (|(~req_pad)) begin
          state_d = ST_IDLE;
          gnt_d   = '1;
        end
      end
      ST_GRANT: begin
        if (!frame_n) begin
          state_d = ST_BUSY;
          owner_d = win_q;
          last_d  = win_q;
        end else if (req_pad[win_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '1;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_IDLE;
          gnt_d   = '1;
          tp_d    = 1'b1;
          last_d  = win_q;
        end else if (bus_idle) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BUSY: begin
        if (bus_idle) begin
          state_d = ST_IDLE;
          gnt_d   = '1;
        end else if (other_req || req_pad[owner]) begin
          // Once dropped the grant stays off until the transaction ends.
          gnt_d = '1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '1;
      end
    endcase
  end

  // State and registered outputs; synchronous reset wins over every transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      gnt_n         <= '1;
      owner         <= LAST_IDX;
      last_q        <= LAST_IDX;
      win_q         <= '0;
      cnt_q         <= '0;
      timeout_pulse <= 1'b0;
      bus_busy      <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_n         <= gnt_d;
      owner         <= owner_d;
      last_q        <= last_d;
      win_q         <= win_d;
      cnt_q         <= cnt_d;
      timeout_pulse <= tp_d;
      bus_busy      <= (state_d == ST_BUSY);
    end
  end

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Bench for pci_rr_arbiter: vector table, directed corner sequences, random vs. model.
module tb_pci_rr_arbiter;

  localparam int N  = 5;
  localparam int T  = 16;
  localparam int PM = 0;

  localparam int P_IDLE  = 0;
  localparam int P_GRANT = 1;
  localparam int P_BUSY  = 2;
  localparam int P_PARK  = 3;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_n;
  logic         frame_n;
  logic         irdy_n;
  logic [N-1:0] gnt_n;
  logic [2:0]   owner;
  logic         bus_busy;
  logic         timeout_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model: phase, current grant holder (-1 none), owner, rr pointer, idle-wait count.
  int     m_phase;
  int     m_holder;
  int     m_owner;
  int     m_ptr;
  int     m_wait;
  bit     m_tp;
  logic [N-1:0] prev_gnt;

  typedef struct {
    logic         r;
    logic [N-1:0] rq;
    logic         f;
    logic         ir;
    logic [N-1:0] g;
    logic [2:0]   o;
    logic         b;
    logic         tp;
  } vec_t;

  vec_t vq[$];

  pci_rr_arbiter #(
    .NUM_MASTERS(N),
    .GNT_TIMEOUT(T),
    .PARK_MASTER(PM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_n         (req_n),
    .frame_n       (frame_n),
    .irdy_n        (irdy_n),
    .gnt_n         (gnt_n),
    .owner         (owner),
    .bus_busy      (bus_busy),
    .timeout_pulse (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit wants(input logic [N-1:0] want, input int i);
    return |(want & (N'(1) << i));
  endfunction

  // First requester strictly after ptr, going around the ring; -1 if none.
  function automatic int next_rr(input int ptr, input logic [N-1:0] want);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (wants(want, c)) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_gnt(input int h);
    if (h < 0) return '1;
    return ~(N'(1) << h);
  endfunction

  task automatic model_step(input logic r, input logic [N-1:0] rq, input logic f, input logic ir);
    bit           idle;
    logic [N-1:0] want;
    int           w;
    idle = f && ir;
    want = ~rq;
    m_tp = 1'b0;
    if (r) begin
      m_phase = P_IDLE; m_holder = -1; m_owner = N - 1; m_ptr = N - 1; m_wait = 0;
      return;
    end
    case (m_phase)
      P_IDLE: begin
        m_holder = -1;
        if (idle) begin
          w = next_rr(m_ptr, want);
          if (w >= 0) begin
            m_phase = P_GRANT; m_holder = w; m_wait = 0;
          end else begin
            m_phase = P_PARK; m_holder = PM;
          end
        end
      end
      P_PARK: begin
        if (!f) begin
          m_phase = P_BUSY; m_owner = PM; m_ptr = PM;
        end else if (wants(want, PM)) begin
          m_phase = P_GRANT; m_wait = 0;
        end else if (want != '0) begin
          m_phase = P_IDLE; m_holder = -1;
        end
      end
      P_GRANT: begin
        if (!f) begin
          m_phase = P_BUSY; m_owner = m_holder; m_ptr = m_holder;
        end else if (!wants(want, m_holder)) begin
          m_phase = P_IDLE; m_holder = -1;
        end else if (m_wait >= T - 1) begin
          m_phase = P_IDLE; m_ptr = m_holder; m_holder = -1; m_tp = 1'b1;
        end else if (idle) begin
          m_wait++;
        end
      end
      default: begin
        if (idle) begin
          m_phase = P_IDLE; m_holder = -1;
        end else if (want != (N'(1) << m_owner)) begin
          m_holder = -1;
        end
      end
    endcase
  endtask

  // One bus clock: drive, clock, advance the model, sample 1 ns after the edge.
  task automatic cyc(input logic r, input logic [N-1:0] rq, input logic f, input logic ir);
    rst = r; req_n = rq; frame_n = f; irdy_n = ir;
    @(posedge clk);
    model_step(r, rq, f, ir);
    #1;
    chk("model_gnt",   8'(gnt_n),         8'(exp_gnt(m_holder)));
    chk("model_owner", 8'(owner),         8'(m_owner));
    chk("model_busy",  8'(bus_busy),      8'(m_phase == P_BUSY));
    chk("model_tp",    8'(timeout_pulse), 8'(m_tp));
    chk("onehot_gnt",  8'($countones(~gnt_n) <= 1), 8'(1));
    chk("dead_cycle",  8'(gnt_n != '1 && prev_gnt != '1 && gnt_n != prev_gnt), 8'(0));
    prev_gnt = gnt_n;
  endtask

  function automatic vec_t mk(input logic r, input logic [N-1:0] rq, input logic f, input logic ir,
                              input logic [N-1:0] g, input logic [2:0] o, input logic b, input logic tp);
    vec_t v;
    v.r = r; v.rq = rq; v.f = f; v.ir = ir; v.g = g; v.o = o; v.b = b; v.tp = tp;
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_n = '1; frame_n = 1'b1; irdy_n = 1'b1;
    prev_gnt = '1;
    m_phase = P_IDLE; m_holder = -1; m_owner = N - 1; m_ptr = N - 1; m_wait = 0; m_tp = 1'b0;

    //            rst   req_n     f     irdy   gnt_n     owner b     tp
    vq.push_back(mk(1'b1, 5'b11111, 1'b1, 1'b1, 5'b11111, 3'd4, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 5'b11110, 1'b1, 1'b1, 5'b11110, 3'd4, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 5'b11110, 1'b0, 1'b1, 5'b11110, 3'd0, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 5'b11110, 1'b0, 1'b0, 5'b11110, 3'd0, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 5'b11111, 1'b0, 1'b0, 5'b11111, 3'd0, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 5'b11111, 1'b1, 1'b0, 5'b11111, 3'd0, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 5'b11111, 1'b1, 1'b1, 5'b11111, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 5'b11111, 1'b1, 1'b1, 5'b11110, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 5'b11111, 1'b1, 1'b1, 5'b11110, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 5'b11011, 1'b1, 1'b1, 5'b11111, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 5'b11011, 1'b1, 1'b1, 5'b11011, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 5'b11011, 1'b0, 1'b1, 5'b11011, 3'd2, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 5'b11011, 1'b0, 1'b0, 5'b11011, 3'd2, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 5'b01011, 1'b0, 1'b0, 5'b11111, 3'd2, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 5'b01011, 1'b1, 1'b0, 5'b11111, 3'd2, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 5'b01011, 1'b1, 1'b1, 5'b11111, 3'd2, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 5'b01111, 1'b1, 1'b1, 5'b01111, 3'd2, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 5'b01111, 1'b0, 1'b1, 5'b01111, 3'd4, 1'b1, 1'b0));
    vq.push_back(mk(1'b1, 5'b01111, 1'b0, 1'b0, 5'b11111, 3'd4, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 5'b11111, 1'b1, 1'b1, 5'b11110, 3'd4, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 5'b11110, 1'b1, 1'b1, 5'b11110, 3'd4, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 5'b11110, 1'b1, 1'b1, 5'b11110, 3'd4, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 5'b11111, 1'b1, 1'b1, 5'b11111, 3'd4, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 5'b11111, 1'b1, 1'b1, 5'b11110, 3'd4, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 5'b11111, 1'b0, 1'b1, 5'b11110, 3'd0, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 5'b11111, 1'b0, 1'b0, 5'b11111, 3'd0, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 5'b11111, 1'b1, 1'b1, 5'b11111, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 5'b11101, 1'b1, 1'b0, 5'b11111, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 5'b11101, 1'b1, 1'b1, 5'b11101, 3'd0, 1'b0, 1'b0));
    vq.push_back(mk(1'b0, 5'b11111, 1'b0, 1'b1, 5'b11101, 3'd1, 1'b1, 1'b0));
    vq.push_back(mk(1'b0, 5'b11111, 1'b1, 1'b1, 5'b11111, 3'd1, 1'b0, 1'b0));

    foreach (vq[i]) begin
      cyc(vq[i].r, vq[i].rq, vq[i].f, vq[i].ir);
      chk($sformatf("vec%0d_gnt", i),   8'(gnt_n),         8'(vq[i].g));
      chk($sformatf("vec%0d_owner", i), 8'(owner),         8'(vq[i].o));
      chk($sformatf("vec%0d_busy", i),  8'(bus_busy),      8'(vq[i].b));
      chk($sformatf("vec%0d_tp", i),    8'(timeout_pulse), 8'(vq[i].tp));
    end

    // Grant timeout for master 1, then the pointer must move past it.
    cyc(1'b1, 5'b11111, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 5'b11101, 1'b1, 1'b1);
      chk("to_hold_gnt", 8'(gnt_n), 8'(5'b11101));
      chk("to_hold_tp",  8'(timeout_pulse), 8'(0));
    end
    cyc(1'b0, 5'b10101, 1'b1, 1'b1);
    chk("to_revoke_gnt", 8'(gnt_n), 8'(5'b11111));
    chk("to_revoke_tp",  8'(timeout_pulse), 8'(1));
    cyc(1'b0, 5'b10101, 1'b1, 1'b1);
    chk("to_next_gnt", 8'(gnt_n), 8'(5'b10111));
    chk("to_next_tp",  8'(timeout_pulse), 8'(0));
    // FRAME# on the exact timeout cycle takes priority.
    for (int i = 0; i < 15; i++) cyc(1'b0, 5'b10101, 1'b1, 1'b1);
    chk("to_edge_gnt", 8'(gnt_n), 8'(5'b10111));
    cyc(1'b0, 5'b10101, 1'b0, 1'b1);
    chk("to_prio_busy",  8'(bus_busy), 8'(1));
    chk("to_prio_tp",    8'(timeout_pulse), 8'(0));
    chk("to_prio_owner", 8'(owner), 8'(3));
    cyc(1'b0, 5'b10101, 1'b0, 1'b0);
    chk("to_busy_drop", 8'(gnt_n), 8'(5'b11111));
    cyc(1'b0, 5'b11111, 1'b1, 1'b1);

    // All masters requesting: owners rotate 0,1,2,3,4,0.
    cyc(1'b1, 5'b00000, 1'b1, 1'b1);
    for (int t = 0; t < 6; t++) begin
      int w;
      w = 0;
      cyc(1'b0, 5'b00000, 1'b1, 1'b1);
      while (gnt_n == '1 && w < 8) begin
        cyc(1'b0, 5'b00000, 1'b1, 1'b1);
        w++;
      end
      chk("rr_grant_seen", 8'(gnt_n != '1), 8'(1));
      cyc(1'b0, 5'b00000, 1'b0, 1'b1);
      chk($sformatf("rr_owner%0d", t), 8'(owner), 8'(t % N));
      cyc(1'b0, 5'b00000, 1'b0, 1'b0);
      chk("rr_release", 8'(gnt_n), 8'(5'b11111));
      cyc(1'b0, 5'b00000, 1'b1, 1'b1);
    end

    // Random traffic against the model.
    cyc(1'b1, 5'b11111, 1'b1, 1'b1);
    begin
      logic [N-1:0] rq;
      rq = '1;
      for (int i = 0; i < 3000; i++) begin
        logic r, f, ir;
        if ($urandom_range(0, 7) == 0) rq = N'($urandom);
        r  = ($urandom_range(0, 299) == 0);
        f  = ($urandom_range(0, 5) != 0);
        ir = ($urandom_range(0, 3) != 0);
        cyc(r, rq, f, ir);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
